// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC/flag controller: opcode encoding, FSM states
// and the absolute branch-target table indexed by an instruction's tgt_idx.
package pc_ctrl_pkg;

    localparam int kPcW  = 10;
    localparam int kIdxW = 5;

    localparam logic [4:0] kNOP = 5'd0;
    localparam logic [4:0] kMOV = 5'd1;
    localparam logic [4:0] kADD = 5'd2;
    localparam logic [4:0] kSUB = 5'd3;
    localparam logic [4:0] kCMP = 5'd4;
    localparam logic [4:0] kBE  = 5'd5;
    localparam logic [4:0] kBL  = 5'd6;
    localparam logic [4:0] kBG  = 5'd7;
    localparam logic [4:0] kBA  = 5'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Unlisted indices point back to address 0.
    localparam logic [kPcW-1:0] kBranchTargets [0:(1<<kIdxW)-1] = '{
        2:       10'd40,
        7:       10'd3,
        31:      10'd1023,
        default: 10'd0
    };

endpackage

// File: rtl/pc_ctrl_branch_lut.sv
// Combinational lookup from a branch-target index to an absolute PC.
module branch_lut
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W  = kPcW,
    parameter int IDX_W = kIdxW
) (
    input  logic [IDX_W-1:0] tgt_idx,
    output logic [PC_W-1:0]  target
);

    assign target = kBranchTargets[tgt_idx];

endmodule

// File: rtl/pc_ctrl.sv
// Program counter, architectural flags and start/halt handshake. Branches
// resolve against the registered flags, so a compare feeds the next branch.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W  = kPcW,
    parameter int IDX_W = kIdxW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [IDX_W-1:0] tgt_idx,
    input  logic             halt_req,
    input  logic             alu_z,
    input  logic             alu_lt,
    input  logic             alu_co,
    output logic [PC_W-1:0]  pc,
    output logic             flag_z,
    output logic             flag_lt,
    output logic             flag_co,
    output logic             branch_taken,
    output logic             running,
    output logic             done
);

    state_t          state;
    logic [PC_W-1:0] branch_target;

    branch_lut #(.PC_W(PC_W), .IDX_W(IDX_W)) u_branch_lut (
        .tgt_idx (tgt_idx),
        .target  (branch_target)
    );

    assign running = (state == RUN);

    always_comb begin
        branch_taken = 1'b0;
        if (state == RUN) begin
            unique case (op)
                kBE:     branch_taken = flag_z;
                kBL:     branch_taken = flag_lt;
                kBG:     branch_taken = !flag_z && !flag_lt;
                kBA:     branch_taken = 1'b1;
                default: branch_taken = 1'b0;
            endcase
        end
    end

    // Halt wins over branch, which wins over sequential increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            flag_z  <= 1'b0;
            flag_lt <= 1'b0;
            flag_co <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state   <= RUN;
                        pc      <= '0;
                        flag_z  <= 1'b0;
                        flag_lt <= 1'b0;
                        flag_co <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state <= HALT;
                        done  <= 1'b1;
                    end else begin
                        pc <= branch_taken ? branch_target : pc + 1'b1;
                        if (op == kCMP) begin
                            flag_z  <= alu_z;
                            flag_lt <= alu_lt;
                        end
                        if (op == kADD) begin
                            flag_co <= alu_co;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: reset/idle, sequencing and wrap, branches,
// carry flag, halt/restart and mid-run reset.
module tb_pc_ctrl;
    import pc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] op;
    logic [4:0] tgt_idx;
    logic       halt_req;
    logic       alu_z, alu_lt, alu_co;
    logic [9:0] pc;
    logic       flag_z, flag_lt, flag_co;
    logic       branch_taken, running, done;

    int checks = 0;
    int errors = 0;

    pc_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .tgt_idx      (tgt_idx),
        .halt_req     (halt_req),
        .alu_z        (alu_z),
        .alu_lt       (alu_lt),
        .alu_co       (alu_co),
        .pc           (pc),
        .flag_z       (flag_z),
        .flag_lt      (flag_lt),
        .flag_co      (flag_co),
        .branch_taken (branch_taken),
        .running      (running),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start    = 1'b0;
        op       = kMOV;
        tgt_idx  = '0;
        halt_req = 1'b0;
        alu_z    = 1'b0;
        alu_lt   = 1'b0;
        alu_co   = 1'b0;
    endtask

    task automatic begin_run();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic advance(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({pc, flag_z, flag_lt, flag_co, done, running} !== 15'd0) begin
                errors++;
                $display("[TB] FAIL idle_hold cycle %0d: pc=%0d flags=%b%b%b done=%b running=%b, want all 0",
                         i, pc, flag_z, flag_lt, flag_co, done, running);
            end
            step();
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (running !== 1'b1 || pc !== 10'd0) begin
            errors++;
            $display("[TB] FAIL start_run: running=%b pc=%0d, want 1 and 0", running, pc);
        end
    endtask

    task automatic test_sequential_wrap();
        logic [9:0] exp_pc;
        begin_run();
        idle_inputs();
        for (int i = 0; i <= 1024; i++) begin
            exp_pc = i[9:0];
            checks++;
            if (pc !== exp_pc) begin
                errors++;
                $display("[TB] FAIL seq_pc step %0d: pc=%0d, want %0d", i, pc, exp_pc);
            end
            step();
        end
    endtask

    task automatic test_cmp_branch();
        begin_run();
        advance(4);
        op = kCMP; alu_z = 1'b1; alu_lt = 1'b0;
        step();
        op = kBE; tgt_idx = 5'd2; alu_z = 1'b0;
        #1;
        checks++;
        if (flag_z !== 1'b1 || pc !== 10'd5 || branch_taken !== 1'b1) begin
            errors++;
            $display("[TB] FAIL be_taken: flag_z=%b pc=%0d taken=%b, want 1 5 1", flag_z, pc, branch_taken);
        end
        step();
        checks++;
        if (pc !== 10'd40) begin
            errors++;
            $display("[TB] FAIL be_target: pc=%0d, want 40", pc);
        end

        begin_run();
        advance(4);
        op = kCMP; alu_z = 1'b0; alu_lt = 1'b0;
        step();
        op = kBE; tgt_idx = 5'd2;
        #1;
        checks++;
        if (branch_taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL be_not_taken: taken=%b, want 0", branch_taken);
        end
        step();
        checks++;
        if (pc !== 10'd6) begin
            errors++;
            $display("[TB] FAIL be_fallthrough: pc=%0d, want 6", pc);
        end
    endtask

    task automatic test_bg_bl_ba();
        begin_run();
        op = kCMP; alu_z = 1'b0; alu_lt = 1'b0;
        step();
        op = kBG; tgt_idx = 5'd7;
        #1;
        checks++;
        if (branch_taken !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bg_taken: taken=%b, want 1", branch_taken);
        end
        step();
        checks++;
        if (pc !== 10'd3) begin
            errors++;
            $display("[TB] FAIL bg_target: pc=%0d, want 3", pc);
        end

        begin_run();
        op = kCMP; alu_z = 1'b0; alu_lt = 1'b1;
        step();
        op = kBG; tgt_idx = 5'd7; alu_lt = 1'b0;
        #1;
        checks++;
        if (branch_taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bg_lt_not_taken: taken=%b, want 0", branch_taken);
        end
        step();
        op = kBL;
        #1;
        checks++;
        if (pc !== 10'd2 || branch_taken !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bl_taken: pc=%0d taken=%b, want 2 1", pc, branch_taken);
        end
        step();
        checks++;
        if (pc !== 10'd3) begin
            errors++;
            $display("[TB] FAIL bl_target: pc=%0d, want 3", pc);
        end

        begin_run();
        op = kBA; tgt_idx = 5'd31;
        step();
        checks++;
        if (pc !== 10'd1023 || {flag_z, flag_lt, flag_co} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL ba_target: pc=%0d flags=%b%b%b, want 1023 000", pc, flag_z, flag_lt, flag_co);
        end
    endtask

    task automatic test_carry();
        begin_run();
        op = kCMP; alu_z = 1'b1; alu_lt = 1'b0;
        step();
        op = kADD; alu_co = 1'b1; alu_z = 1'b0; alu_lt = 1'b1;
        step();
        checks++;
        if ({flag_z, flag_lt, flag_co} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL add_carry: flags zlc=%b%b%b, want 101", flag_z, flag_lt, flag_co);
        end
        op = kCMP; alu_co = 1'b0; alu_z = 1'b0; alu_lt = 1'b1;
        step();
        checks++;
        if ({flag_z, flag_lt, flag_co} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL cmp_keeps_co: flags zlc=%b%b%b, want 011", flag_z, flag_lt, flag_co);
        end
    endtask

    task automatic test_halt_restart();
        begin_run();
        advance(5);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (pc !== 10'd6 || running !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_in_run: pc=%0d running=%b, want 6 1", pc, running);
        end
        advance(6);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        checks++;
        if (done !== 1'b1 || running !== 1'b0 || pc !== 10'd12) begin
            errors++;
            $display("[TB] FAIL halt: done=%b running=%b pc=%0d, want 1 0 12", done, running, pc);
        end
        for (int i = 0; i < 3; i++) begin
            op = kBA;
            #1;
            checks++;
            if (pc !== 10'd12 || done !== 1'b1 || branch_taken !== 1'b0) begin
                errors++;
                $display("[TB] FAIL halt_hold %0d: pc=%0d done=%b taken=%b, want 12 1 0", i, pc, done, branch_taken);
            end
            step();
        end
        op = kMOV;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (pc !== 10'd0 || done !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart: pc=%0d done=%b running=%b, want 0 0 1", pc, done, running);
        end
    endtask

    task automatic test_reset_mid_run();
        begin_run();
        advance(8);
        op = kCMP; alu_z = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (pc !== 10'd9 || flag_z !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset: pc=%0d flag_z=%b, want 9 1", pc, flag_z);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (running !== 1'b0 || pc !== 10'd0 || {flag_z, flag_lt, flag_co} !== 3'b000 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_run: running=%b pc=%0d flags=%b%b%b done=%b, want 0 0 000 0",
                     running, pc, flag_z, flag_lt, flag_co, done);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_sequential_wrap();
        test_cmp_branch();
        test_bg_bl_ba();
        test_carry();
        test_halt_restart();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter and flag controller for the 8-bit datapath. It latches the ALU's condition outputs (z, lt, co) into an architectural flag register and resolves the branch opcodes (kBE/kBL/kBG/kBA) against those flags. It advances or redirects the PC each cycle and runs the start/done handshake with the testbench. It sits on the consuming side of the ALU flag outputs, between the ALU and instruction memory.

## Interface
Parameters:
- PC_W, 10, program-counter width; instruction memory depth is 2^PC_W.
- IDX_W, 5, branch-target index width; the LUT has 2^IDX_W entries.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a program run from PC 0.
- op  input  5  decoded opcode of the instruction at pc (definitions package encoding).
- tgt_idx  input  IDX_W  branch-target index field of the current instruction.
- halt_req  input  1  current instruction is the halt instruction.
- alu_z  input  1  ALU equal flag.
- alu_lt  input  1  ALU less-than flag.
- alu_co  input  1  ALU carry-out.
- pc  output  PC_W  current instruction address (registered).
- flag_z, flag_lt, flag_co  output  1 each  architectural flags (registered).
- branch_taken  output  1  combinational; the current instruction redirects the PC.
- running  output  1  high in RUN.
- done  output  1  high in HALT (registered).

## Operation
States: IDLE, RUN, HALT.

- Reset behaviour (any state, including mid-run): state goes to IDLE; pc=0; flag_z=flag_lt=flag_co=0; done=0.
- IDLE:
  - start=1 → RUN; pc=0; all flags cleared.
  - Otherwise hold.
- RUN: one instruction per cycle. Priority is halt, then branch, then increment.
  - halt_req=1 → HALT; pc holds; flags hold.
  - branch_taken=1 → pc = branch_lut[tgt_idx].
  - else pc = pc+1. At pc = 2^PC_W-1 this wraps to 0 with no error.
- Branch conditions, evaluated on the registered flags only:
  - kBE: taken if flag_z.
  - kBL: taken if flag_lt.
  - kBG: taken if !flag_z && !flag_lt.
  - kBA: always taken.
  - branch_taken=0 for every other op, and whenever state≠RUN.
- Flag update in RUN, when halt_req=0:
  - kCMP: flag_z←alu_z and flag_lt←alu_lt; flag_co holds.
  - kADD: flag_co←alu_co; z and lt hold.
  - All other ops hold all flags. Flags never change outside RUN.
- start while in RUN is ignored.
- HALT:
  - done=1 and is held.
  - start=1 → RUN; pc=0; flags cleared; done=0.
- halt_req outside RUN is ignored.
- Unknown opcodes advance pc+1 and are otherwise ignored.

## Timing
- pc, flags and done are registered and change only on clk rising edge.
- A CMP presented at cycle n updates flags visible at n+1. A branch at n+1 uses them: zero-bubble compare→branch.
- A branch at cycle n gives pc = target at n+1. There is no delay slot.
- halt_req sampled at cycle n gives done=1 and running=0 at n+1.
- start sampled at cycle n gives running=1, pc=0 at n+1. The instruction at address 0 executes at n+1.
- branch_taken is valid in the same cycle as op, tgt_idx and the flags. It has no register stage.

## Structure
- The definitions package already holds the opcode constants (kADD, kCMP, kBE, kBL, kBG, kBA).
- Add to the package:
  - a state enum typedef {IDLE, RUN, HALT};
  - the branch-target table as a constant array kBranchTargets[2^IDX_W] of PC_W-bit absolute addresses.
- Sub-module branch_lut: combinational; maps tgt_idx to a PC_W-bit target from kBranchTargets.
- pc_ctrl instantiates branch_lut once.
- Test table entries: idx 2=40, idx 7=3, idx 31=1023.

## Test plan
- Reset/idle: hold reset 2 cycles, then no start for 5 cycles → pc=0, flags 000, done=0, running=0 throughout. Pulse start → next cycle running=1, pc=0.
- Sequential and wrap: run with op=kMOV and no halt for 1025 cycles → pc counts 0..1023, then 0.
- Compare→branch: kCMP with alu_z=1, alu_lt=0 at pc=4, then kBE tgt_idx=2 at pc=5 → flag_z=1 at the kBE cycle, branch_taken=1, pc=40 the following cycle. Repeat with alu_z=0 → pc=6.
- kBG/kBL/kBA:
  - CMP z=0, lt=0 then kBG idx=7 → pc=3.
  - CMP lt=1 then kBG → not taken; kBL idx=7 → pc=3.
  - kBA idx=31 with flags 000 → pc=1023.
- Carry: kADD with alu_co=1 → flag_co=1, z and lt unchanged. A later kCMP leaves flag_co=1.
- Halt and restart, reset mid-run:
  - halt_req at pc=12 → done=1 next cycle, pc stays 12. 3 idle cycles hold; start → pc=0, done=0.
  - reset asserted in RUN at pc=9 with flag_z=1 → next cycle IDLE, pc=0, flags 000.
